// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: command FIFO + load/shift/capture FSM driving a shift register.
// Optional shadow check enabled with `define SHIFT_SEQ_SHADOW_CHECK_EN.
module shift_cmd_sequencer #(
    parameter int WIDTH      = 16,
    parameter int CNT_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_load,
    output logic             sr_shift_en,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             err_mismatch
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE
    } state_t;

    typedef struct packed {
        logic [1:0]       mode;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] data;
    } cmd_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    cmd_t             head;
    cmd_t             cmd_in;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) &&
                       (wr_ptr[PW] != rd_ptr[PW]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr[PW-1:0]];
    assign busy      = (state != IDLE) || !empty;

    assign cmd_in.mode  = cmd_mode;
    assign cmd_in.count = cmd_count;
    assign cmd_in.data  = cmd_data;

    // FIFO storage; contents are don't-care while pointers say empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= cmd_in;
        end
    end

    // FIFO pointers with wrap bit for full/empty distinction
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Next-state logic; pop only when the result slot is free or draining now
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && (!res_valid || res_ready)) begin
                    pop     = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = (cnt != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) state_n = CAPTURE;
            end
            CAPTURE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and registered shift-register controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sr_load     <= 1'b0;
            sr_shift_en <= 1'b0;
            sr_mode     <= '0;
            sr_data_in  <= '0;
        end else begin
            state       <= state_n;
            sr_load     <= (state_n == LOAD);
            sr_shift_en <= (state_n == SHIFT);
            if (pop) begin
                cnt        <= head.count;
                sr_mode    <= head.mode;
                sr_data_in <= head.data;
            end else if (state == SHIFT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Result register: captured on leaving CAPTURE, held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (state == CAPTURE) begin
            res_valid <= 1'b1;
            res_data  <= sr_data_out;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef SHIFT_SEQ_SHADOW_CHECK_EN

    logic [WIDTH-1:0] shadow;

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        unique case (m)
            2'b00:   r = {d[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, d[WIDTH-1:1]};
            2'b10:   r = {d[WIDTH-2:0], d[WIDTH-1]};
            default: r = {d[0], d[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Shadow copy of the external register; sticky error on capture mismatch
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            err_mismatch <= 1'b0;
        end else begin
            if (state == LOAD) begin
                shadow <= sr_data_in;
            end else if (state == SHIFT) begin
                shadow <= shift_step(shadow, sr_mode);
            end
            if (state == CAPTURE && sr_data_out != shadow) begin
                err_mismatch <= 1'b1;
            end
        end
    end

`else

    assign err_mismatch = 1'b0;

`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb_shift_cmd_sequencer: scoreboard bench with a behavioural shift register.
// Shadow-check case runs when SHIFT_SEQ_SHADOW_CHECK_EN is defined.
module tb_shift_cmd_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             sr_load;
    logic             sr_shift_en;
    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_data_in;
    logic [WIDTH-1:0] sr_data_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic             err_mismatch;

    logic             rand_mode;
    logic             rr_fixed;
    logic             rr_rand;
    logic             corrupt;
    logic [WIDTH-1:0] sr_q = '0;

    int vec_cnt = 0;
    int err_cnt = 0;
    int overlap = 0;
    int shift_cycles = 0;
    logic [WIDTH-1:0] exp_q [$];

    shift_cmd_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode),
        .cmd_count(cmd_count),
        .cmd_data(cmd_data),
        .sr_load(sr_load),
        .sr_shift_en(sr_shift_en),
        .sr_mode(sr_mode),
        .sr_data_in(sr_data_in),
        .sr_data_out(sr_data_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .busy(busy),
        .err_mismatch(err_mismatch)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m
    );
        case (m)
            2'b00:   return {d[WIDTH-2:0], 1'b0};
            2'b01:   return {1'b0, d[WIDTH-1:1]};
            2'b10:   return {d[WIDTH-2:0], d[WIDTH-1]};
            default: return {d[0], d[WIDTH-1:1]};
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] model(
        input logic [1:0]       m,
        input logic [CNT_W-1:0] c,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r = d;
        for (int i = 0; i < int'(c); i++) r = step(r, m);
        return r;
    endfunction

    // external universal shift register
    always @(posedge clk) begin
        if (sr_load) sr_q <= sr_data_in;
        else if (sr_shift_en) sr_q <= step(sr_q, sr_mode);
    end

    assign sr_data_out = sr_q ^ {{(WIDTH-1){1'b0}}, corrupt};
    assign res_ready   = rand_mode ? rr_rand : rr_fixed;

    always @(posedge clk) begin
        #1 rr_rand = 1'($urandom_range(0, 1));
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // result scoreboard and control-line monitor
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
            else chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
        end
        if (sr_load && sr_shift_en) overlap++;
        if (sr_shift_en) shift_cycles++;
    end

    task automatic push_cmd(
        input logic [1:0]       m,
        input logic [CNT_W-1:0] c,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] e
    );
        int w = 0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_count = c;
        cmd_data  = d;
        @(negedge clk);
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int lim);
        int n = 0;
        while ((busy || res_valid) && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy || res_valid) chk({tag, "_drain_timeout"}, 1, 0);
    endtask

    task automatic run_one(
        input string            tag,
        input logic [1:0]       m,
        input logic [CNT_W-1:0] c,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] e
    );
        int n = 0;
        int s0 = shift_cycles;
        push_cmd(m, c, d, e);
        while (!res_valid && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(c) + 3);
        drain(tag, 100);
        chk({tag, "_shift_cycles"}, 32'(shift_cycles - s0), 32'(c));
    endtask

    initial begin
        logic [1:0]       rm;
        logic [CNT_W-1:0] rc;
        logic [WIDTH-1:0] rd;
        int w;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_count = '0;
        cmd_data  = '0;
        rand_mode = 1'b0;
        rr_fixed  = 1'b1;
        corrupt   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ctrl",
            {26'd0, res_valid, sr_load, sr_shift_en, busy, cmd_ready, err_mismatch},
            32'b000010);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_sr_data_in", 32'(sr_data_in), 0);
        chk("rst_sr_mode", 32'(sr_mode), 0);

        run_one("shl1",    2'b00, 5'd1,  16'hAAAA, 16'h5554);
        run_one("rotl4",   2'b10, 5'd4,  16'h1234, 16'h2341);
        run_one("shr3",    2'b01, 5'd3,  16'h8001, 16'h1000);
        run_one("rotr16",  2'b11, 5'd16, 16'hBEEF, 16'hBEEF);
        run_one("shl0",    2'b00, 5'd0,  16'hAAAA, 16'hAAAA);
        run_one("shl20",   2'b00, 5'd20, 16'hFFFF, 16'h0000);
        run_one("rotl17",  2'b10, 5'd17, 16'h8001, 16'h0003);
        run_one("shr31",   2'b01, 5'd31, 16'hFFFF, 16'h0000);

        // back-pressure: result held, FIFO fills, sixth push refused
        rr_fixed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd = 16'h1000 + 16'(i * 16'h0111);
            push_cmd(2'b10, 5'(i + 1), rd, model(2'b10, 5'(i + 1), rd));
        end
        cmd_valid = 1'b1;
        cmd_mode  = 2'b00;
        cmd_count = 5'd2;
        cmd_data  = 16'h00FF;
        repeat (20) @(negedge clk);
        chk("bp_cmd_ready", 32'(cmd_ready), 0);
        chk("bp_res_valid", 32'(res_valid), 1);
        chk("bp_res_data", 32'(res_data), 32'(exp_q[0]));
        chk("bp_busy", 32'(busy), 1);
        repeat (10) @(negedge clk);
        chk("bp_res_hold", 32'(res_data), 32'(exp_q[0]));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rr_fixed = 1'b1;
        drain("bp", 300);
        chk("bp_all_out", 32'(exp_q.size()), 0);

        // random traffic with random result back-pressure
        rand_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rm = 2'($urandom_range(0, 3));
            rc = 5'($urandom_range(0, 31));
            rd = 16'($urandom());
            push_cmd(rm, rc, rd, model(rm, rc, rd));
        end
        drain("rand", 3000);
        rand_mode = 1'b0;
        chk("rand_all_out", 32'(exp_q.size()), 0);

        // reset in the middle of a long shift with another command queued
        push_cmd(2'b00, 5'd10, 16'h0F0F, 16'h0000);
        push_cmd(2'b01, 5'd2, 16'hF000, 16'h0000);
        w = 0;
        while (!sr_shift_en && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("mid_shift_reached", 32'(sr_shift_en), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        chk("mrst_ctrl",
            {26'd0, res_valid, sr_load, sr_shift_en, busy, cmd_ready, err_mismatch},
            32'b000010);
        chk("mrst_sr_data_in", 32'(sr_data_in), 0);
        chk("mrst_res_data", 32'(res_data), 0);
        repeat (30) @(posedge clk);
        #1;
        chk("mrst_stays_idle", {30'd0, busy, res_valid}, 0);
        run_one("post_rst", 2'b11, 5'd5, 16'h00F1, 16'h8807);

`ifdef SHIFT_SEQ_SHADOW_CHECK_EN
        chk("shadow_clean", 32'(err_mismatch), 0);
        corrupt = 1'b1;
        push_cmd(2'b10, 5'd2, 16'h00F0, 16'h03C1);
        drain("shadow", 100);
        corrupt = 1'b0;
        chk("shadow_err_set", 32'(err_mismatch), 1);
        run_one("shadow_after", 2'b00, 5'd1, 16'h0001, 16'h0002);
        chk("shadow_err_sticky", 32'(err_mismatch), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("shadow_err_clear", 32'(err_mismatch), 0);
`else
        chk("err_tied_low", 32'(err_mismatch), 0);
`endif

        chk("no_load_shift_overlap", 32'(overlap), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
